// File: rtl/me_load_result_stage.sv
// me_load_result_stage: MEM-stage result register with variable-latency load handshake, sub-word extraction and bus timeout
module me_load_result_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [1:0]        ex_mem_ctrl,
  input  logic [1:0]        ex_load_mode,
  input  logic              ex_byte_hi,
  input  logic              flush,
  output logic              mem_rd_req,
  output logic [DATA_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              me_stall,
  output logic              me_valid,
  output logic [REG_AW-1:0] me_rd,
  output logic [DATA_W-1:0] me_result,
  output logic              me_bus_err
);
  localparam int SUB_W = DATA_W / 2;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d, result_q, result_d, ext;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] mode_q, mode_d;
  logic [SUB_W-1:0] sub;
  logic hi_q, hi_d, valid_q, valid_d, err_q, err_d, tmo;
  logic unused_store;
  assign unused_store = ex_mem_ctrl[0];
  assign sub = hi_q ? mem_rd_data[DATA_W-1:SUB_W] : mem_rd_data[SUB_W-1:0];
  assign ext = mode_q == 2'b01 ? {{SUB_W{1'b0}}, sub} :
               mode_q == 2'b10 ? {{SUB_W{sub[SUB_W-1]}}, sub} : mem_rd_data;
  assign tmo = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1) && !mem_rd_ack;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    result_d = result_q;
    rd_d     = rd_q;
    mode_d   = mode_q;
    hi_d     = hi_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    cnt_d    = state_q == IDLE ? '0 : CW'(cnt_q + 1'b1);
    case (state_q)
      IDLE: if (ex_valid && !flush) begin
        rd_d = ex_rd;
        if (ex_mem_ctrl[1]) begin
          addr_d  = ex_result;
          mode_d  = ex_load_mode;
          hi_d    = ex_byte_hi;
          state_d = WAIT;
        end else begin
          result_d = ex_result;
          valid_d  = 1'b1;
        end
      end
      WAIT: if (mem_rd_ack) begin
        state_d = IDLE;
        if (!flush) begin
          result_d = ext;
          valid_d  = 1'b1;
        end
      end else if (flush) begin
        // a flushed load that also times out is simply abandoned, no error
        state_d = tmo ? IDLE : DRAIN;
      end else if (tmo) begin
        state_d  = IDLE;
        result_d = '0;
        valid_d  = 1'b1;
        err_d    = 1'b1;
      end
      DRAIN: if (mem_rd_ack || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      result_q <= '0;
      rd_q     <= '0;
      mode_q   <= '0;
      hi_q     <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      mode_q   <= mode_d;
      hi_q     <= hi_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end
  assign mem_rd_req  = state_q != IDLE;
  assign me_stall    = state_q != IDLE;
  assign mem_rd_addr = addr_q;
  assign me_result   = result_q;
  assign me_rd       = rd_q;
  assign me_valid    = valid_q;
  assign me_bus_err  = err_q;
endmodule
